// File: rtl/game_round_if.sv
// Board/datapath <-> round controller signal bundle.
// The master drives keys, frame strobe and collision reports; the slave returns status.
// All slave outputs are registered inside the controller.
interface game_round_if #(
  parameter int w_score = 8
);
  logic               start_key;
  logic               frame_strobe;
  logic               hit;
  logic               miss;
  logic               launch;
  logic               game_on;
  logic               flash;
  logic [2:0]         state;
  logic [w_score-1:0] score;
  logic [1:0]         lives;

  modport master (
    output start_key, frame_strobe, hit, miss,
    input  launch, game_on, flash, state, score, lives
  );

  modport slave (
    input  start_key, frame_strobe, hit, miss,
    output launch, game_on, flash, state, score, lives
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for a ball game: start, launch, score/lives bookkeeping, hold and game-over timers.
// Latency: every output is registered and changes one clock after the qualifying input.
// No backpressure: inputs are sampled every cycle; strobes and levels arriving in ignoring states are dropped.
module game_round_ctrl #(
  parameter int init_lives  = 3,
  parameter int hold_frames = 30,
  parameter int over_frames = 120,
  parameter int w_score     = 8
) (
  input  logic       clk,
  input  logic       rst,
  game_round_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PLAY = 3'd2,
    ST_HIT  = 3'd3,
    ST_MISS = 3'd4,
    ST_OVER = 3'd5
  } state_t;

  localparam logic [1:0]         LIVES_INIT = 2'(init_lives);
  localparam logic [8:0]         HOLD_N     = 9'(hold_frames);
  localparam logic [8:0]         OVER_N     = 9'(over_frames);
  localparam logic [w_score-1:0] SCORE_MAX  = '1;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [w_score-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic               key_q;
  // Set once start_key has been seen low since reset, so a key held across
  // reset release cannot masquerade as a fresh press.
  logic               key_seen_low_q;
  logic               launch_q, game_on_q, flash_q;
  logic               start_edge;
  logic [8:0]         cnt_inc;

  assign start_edge = bus.start_key & ~key_q & key_seen_low_q;
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;

  // Next-state, counter, score and lives decisions for the round sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    lives_d = lives_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          score_d = '0;
          lives_d = LIVES_INIT;
          cnt_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // hit has priority over a simultaneous miss
        if (bus.hit) begin
          cnt_d   = '0;
          state_d = ST_HIT;
          if (score_q != SCORE_MAX) begin
            score_d = score_q + 1'b1;
          end
        end else if (bus.miss) begin
          cnt_d = '0;
          if (lives_q <= 2'd1) begin
            // last life lost: straight to game over, no hold in MISS
            lives_d = 2'd0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_MISS;
          end
        end
      end
      ST_HIT, ST_MISS: begin
        if (bus.frame_strobe) begin
          if (cnt_inc == HOLD_N) begin
            cnt_d   = '0;
            state_d = ST_ARM;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      ST_OVER: begin
        if (bus.frame_strobe) begin
          if (cnt_inc == OVER_N) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      score_q        <= '0;
      lives_q        <= '0;
      key_q          <= 1'b0;
      key_seen_low_q <= 1'b0;
      launch_q       <= 1'b0;
      game_on_q      <= 1'b0;
      flash_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      key_q          <= bus.start_key;
      key_seen_low_q <= key_seen_low_q | ~bus.start_key;
      launch_q       <= (state_d == ST_ARM);
      game_on_q      <= (state_d == ST_PLAY);
      flash_q        <= (state_d == ST_HIT) || (state_d == ST_MISS) || (state_d == ST_OVER);
    end
  end

  assign bus.launch  = launch_q;
  assign bus.game_on = game_on_q;
  assign bus.flash   = flash_q;
  assign bus.state   = state_q;
  assign bus.score   = score_q;
  assign bus.lives   = lives_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: default-parameter instance plus a 2-bit score instance.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Expected values are hand-derived constants.
module tb_game_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  game_round_if #(.w_score(8)) bus_a ();
  game_round_if #(.w_score(2)) bus_b ();

  game_round_ctrl #(
    .init_lives(3), .hold_frames(30), .over_frames(120), .w_score(8)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  game_round_ctrl #(
    .init_lives(3), .hold_frames(2), .over_frames(2), .w_score(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.frame_strobe = 1'b1;
      tick();
      bus_a.frame_strobe = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.start_key = 1'b0; bus_a.frame_strobe = 1'b0; bus_a.hit = 1'b0; bus_a.miss = 1'b0;
    bus_b.start_key = 1'b0; bus_b.frame_strobe = 1'b0; bus_b.hit = 1'b0; bus_b.miss = 1'b0;
    tick();
    tick();
    chk("rst_state",   32'(bus_a.state),   0);
    chk("rst_score",   32'(bus_a.score),   0);
    chk("rst_lives",   32'(bus_a.lives),   0);
    chk("rst_launch",  32'(bus_a.launch),  0);
    chk("rst_game_on", 32'(bus_a.game_on), 0);
    chk("rst_flash",   32'(bus_a.flash),   0);
    rst = 1'b0;
    tick();

    // ---- 2-bit score instance: saturation at 3 ----
    bus_b.start_key = 1'b1;
    tick();
    chk("b_arm", 32'(bus_b.state), 1);
    bus_b.start_key = 1'b0;
    tick();
    chk("b_play", 32'(bus_b.state), 2);
    for (int i = 0; i < 7; i++) begin
      bus_b.hit = 1'b1;
      tick();
      bus_b.hit = 1'b0;
      chk("b_hit_state", 32'(bus_b.state), 3);
      chk("b_score_sat", 32'(bus_b.score), (i < 3) ? i + 1 : 3);
      for (int k = 0; k < 2; k++) begin
        bus_b.frame_strobe = 1'b1;
        tick();
        bus_b.frame_strobe = 1'b0;
        tick();
      end
      chk("b_relaunch_play", 32'(bus_b.state), 2);
    end

    // ---- default instance: start, launch, play ----
    bus_a.start_key = 1'b1;
    tick();
    chk("a_arm_state",  32'(bus_a.state),  1);
    chk("a_arm_launch", 32'(bus_a.launch), 1);
    chk("a_arm_lives",  32'(bus_a.lives),  3);
    chk("a_arm_score",  32'(bus_a.score),  0);
    tick();
    chk("a_play_state",   32'(bus_a.state),   2);
    chk("a_play_launch",  32'(bus_a.launch),  0);
    chk("a_play_game_on", 32'(bus_a.game_on), 1);
    bus_a.start_key = 1'b0;
    tick();
    bus_a.start_key = 1'b1;
    tick();
    chk("a_play_ignores_start", 32'(bus_a.state),  2);
    chk("a_play_no_launch",     32'(bus_a.launch), 0);
    bus_a.start_key = 1'b0;
    tick();

    // hit, 30 strobes, relaunch
    bus_a.hit = 1'b1;
    tick();
    bus_a.hit = 1'b0;
    chk("a_hit_state",   32'(bus_a.state),   3);
    chk("a_hit_score",   32'(bus_a.score),   1);
    chk("a_hit_flash",   32'(bus_a.flash),   1);
    chk("a_hit_game_on", 32'(bus_a.game_on), 0);
    strobe_a(29);
    chk("a_hit_hold29", 32'(bus_a.state), 3);
    bus_a.frame_strobe = 1'b1;
    tick();
    bus_a.frame_strobe = 1'b0;
    chk("a_relaunch_state",  32'(bus_a.state),  1);
    chk("a_relaunch_launch", 32'(bus_a.launch), 1);
    tick();
    chk("a_replay_state",  32'(bus_a.state),  2);
    chk("a_replay_launch", 32'(bus_a.launch), 0);

    // hit and miss together, with a strobe on the entry cycle
    bus_a.hit = 1'b1; bus_a.miss = 1'b1; bus_a.frame_strobe = 1'b1;
    tick();
    bus_a.hit = 1'b0; bus_a.miss = 1'b0; bus_a.frame_strobe = 1'b0;
    chk("a_both_state", 32'(bus_a.state), 3);
    chk("a_both_score", 32'(bus_a.score), 2);
    chk("a_both_lives", 32'(bus_a.lives), 3);
    strobe_a(29);
    chk("a_entry_strobe_ignored", 32'(bus_a.state), 3);
    bus_a.frame_strobe = 1'b1;
    tick();
    bus_a.frame_strobe = 1'b0;
    chk("a_both_relaunch", 32'(bus_a.state), 1);
    tick();

    // two ordinary misses
    for (int lv = 2; lv >= 1; lv--) begin
      bus_a.miss = 1'b1;
      tick();
      bus_a.miss = 1'b0;
      chk("a_miss_state", 32'(bus_a.state), 4);
      chk("a_miss_lives", 32'(bus_a.lives), lv);
      chk("a_miss_flash", 32'(bus_a.flash), 1);
      strobe_a(29);
      bus_a.frame_strobe = 1'b1;
      tick();
      bus_a.frame_strobe = 1'b0;
      chk("a_miss_relaunch", 32'(bus_a.state), 1);
      tick();
    end

    // last miss goes straight to OVER
    bus_a.miss = 1'b1;
    tick();
    bus_a.miss = 1'b0;
    chk("a_over_state", 32'(bus_a.state), 5);
    chk("a_over_lives", 32'(bus_a.lives), 0);
    chk("a_over_flash", 32'(bus_a.flash), 1);
    chk("a_over_score", 32'(bus_a.score), 2);
    bus_a.start_key = 1'b1; bus_a.hit = 1'b1;
    tick();
    bus_a.start_key = 1'b0; bus_a.hit = 1'b0;
    chk("a_over_ignores_inputs", 32'(bus_a.state), 5);
    chk("a_over_score_held",     32'(bus_a.score), 2);
    strobe_a(119);
    chk("a_over_hold119", 32'(bus_a.state), 5);
    bus_a.frame_strobe = 1'b1;
    tick();
    bus_a.frame_strobe = 1'b0;
    chk("a_idle_state",    32'(bus_a.state), 0);
    chk("a_idle_score",    32'(bus_a.score), 2);
    chk("a_idle_flash",    32'(bus_a.flash), 0);
    chk("a_idle_lives",    32'(bus_a.lives), 0);
    tick();

    // new game, then asynchronous reset mid-HIT with start_key held
    bus_a.start_key = 1'b1;
    tick();
    chk("a_new_arm", 32'(bus_a.state), 1);
    tick();
    bus_a.hit = 1'b1;
    tick();
    bus_a.hit = 1'b0;
    chk("a_new_hit_state", 32'(bus_a.state), 3);
    chk("a_new_hit_score", 32'(bus_a.score), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state",  32'(bus_a.state),  0);
    chk("async_rst_score",  32'(bus_a.score),  0);
    chk("async_rst_lives",  32'(bus_a.lives),  0);
    chk("async_rst_flash",  32'(bus_a.flash),  0);
    chk("async_rst_launch", 32'(bus_a.launch), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_key_no_launch", 32'(bus_a.launch), 0);
      chk("held_key_idle",      32'(bus_a.state),  0);
    end
    bus_a.start_key = 1'b0;
    tick();
    bus_a.start_key = 1'b1;
    tick();
    chk("repress_arm",    32'(bus_a.state),  1);
    chk("repress_launch", 32'(bus_a.launch), 1);
    bus_a.start_key = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
